instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit.sv | 125 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Program-counter and instruction-fetch stage: holds the PC, reads the internal ROM, hands {pc, instr} to decode.
// Latency: one cycle from PC to registered instr/pc outputs; first valid on the 2nd edge after reset release.
// Backpressure: valid & !ready freezes outputs and PC; redirect flushes. Optional macro FETCH_BOUNDS_CHECK_EN adds faulting.
module instr_fetch_unit #(
    parameter int              XLEN      = 32,
    parameter int              ROM_DEPTH = 64,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic            clk_i_fetch,
    input  logic            reset_i_fetch,
    input  logic            ready_i_fetch,
    input  logic            redirect_i_fetch,
    input  logic [XLEN-1:0] redirect_pc_i_fetch,
    output logic            valid_o_fetch,
    output logic [XLEN-1:0] instr_o_fetch,
    output logic [XLEN-1:0] pc_o_fetch,
    output logic [31:0]     fetch_count_o_fetch,
    output logic            fault_o_fetch
);

    localparam int IDX_W = $clog2(ROM_DEPTH);

    // Byte span covered by the ROM; any PC at or above this is outside it.
    localparam logic [XLEN-1:0] ROM_BYTES = XLEN'(ROM_DEPTH * 4);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FAULT = 2'd2;

    // Instruction store; contents are loaded from outside (no write port).
    logic [XLEN-1:0] rom [0:ROM_DEPTH-1] = '{default: '0};

    logic [1:0]      state;
    logic [XLEN-1:0] pc_q;
    logic            valid_q;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] pc_out_q;
    logic [31:0]     fetch_count_q;

    logic [IDX_W-1:0] rom_idx;
    logic             advance;
    logic             accept;
    logic             fetch_bad;

    // Low two PC bits select a byte within a word, so the word index starts at bit 2.
    assign rom_idx = pc_q[IDX_W+1:2];
    assign advance = !valid_q || ready_i_fetch;
    assign accept  = valid_q && ready_i_fetch;

    // Decide whether the PC about to be fetched is illegal (only when bounds checking is built in).
    always_comb begin
        fetch_bad = 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
        if ((pc_q[1:0] != 2'b00) || (pc_q >= ROM_BYTES)) begin
            fetch_bad = 1'b1;
        end
`endif
    end

    // PC, fetch outputs and state sequencing; redirect outranks a normal advance.
    always_ff @(posedge clk_i_fetch or posedge reset_i_fetch) begin
        if (reset_i_fetch) begin
            state    <= IDLE;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            instr_q  <= '0;
            pc_out_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // One settling edge after reset before the first fetch.
                    state <= RUN;
                end
                RUN: begin
                    if (redirect_i_fetch) begin
                        // Flush the current output; instr/pc keep their old values but are invalid.
                        valid_q <= 1'b0;
                        pc_q    <= redirect_pc_i_fetch;
                    end else if (advance) begin
                        if (fetch_bad) begin
                            // Report the offending PC and park until reset.
                            state    <= FAULT;
                            pc_out_q <= pc_q;
                            valid_q  <= 1'b0;
                        end else begin
                            instr_q  <= rom[rom_idx];
                            pc_out_q <= pc_q;
                            valid_q  <= 1'b1;
                            pc_q     <= pc_q + XLEN'(4);
                        end
                    end
                end
                FAULT: begin
                    // Sticky: ready and redirect are ignored, only reset leaves.
                    valid_q <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Count every handshake with decode, including one that coincides with a redirect.
    always_ff @(posedge clk_i_fetch or posedge reset_i_fetch) begin
        if (reset_i_fetch) begin
            fetch_count_q <= '0;
        end else if (accept) begin
            fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

    assign valid_o_fetch       = valid_q;
    assign instr_o_fetch       = instr_q;
    assign pc_o_fetch          = pc_out_q;
    assign fetch_count_o_fetch = fetch_count_q;

`ifdef FETCH_BOUNDS_CHECK_EN
    assign fault_o_fetch = (state == FAULT);
`else
    assign fault_o_fetch = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized ready/redirect traffic against a reference model.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
// Build with or without FETCH_BOUNDS_CHECK_EN; expectations follow the macro.
module tb_instr_fetch_unit;

    localparam int DEPTH = 64;
`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] count;
    logic        fault;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] romm [0:DEPTH-1];
    bit          m_started;
    bit          m_faulted;
    logic [31:0] m_pc;
    bit          m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pco;
    logic [31:0] m_cnt;

    wire [97:0] obs = {valid, pc, instr, count, fault};
    logic [97:0] exp_v;

    instr_fetch_unit #(.XLEN(32), .ROM_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk_i_fetch        (clk),
        .reset_i_fetch      (rst),
        .ready_i_fetch      (ready),
        .redirect_i_fetch   (redirect),
        .redirect_pc_i_fetch(redirect_pc),
        .valid_o_fetch      (valid),
        .instr_o_fetch      (instr),
        .pc_o_fetch         (pc),
        .fetch_count_o_fetch(count),
        .fault_o_fetch      (fault)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_started = 0; m_faulted = 0; m_pc = 32'h0; m_valid = 0;
        m_instr = '0; m_pco = '0; m_cnt = '0;
    endtask

    // One rising edge of the specified behaviour, given the inputs held across it.
    task automatic model_edge(input bit rdy, input bit redir, input logic [31:0] tgt);
        if (!m_started) begin
            m_started = 1;
        end else if (!m_faulted) begin
            if (m_valid && rdy) m_cnt = m_cnt + 1;
            if (redir) begin
                m_valid = 0;
                m_pc = tgt;
            end else if (!m_valid || rdy) begin
                if (BOUNDS && ((m_pc % 4) != 0 || m_pc >= DEPTH * 4)) begin
                    m_faulted = 1; m_pco = m_pc; m_valid = 0;
                end else begin
                    m_instr = romm[(m_pc / 4) % DEPTH];
                    m_pco = m_pc;
                    m_valid = 1;
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic load_rom(input bit rnd);
        for (int i = 0; i < DEPTH; i++) begin
            romm[i] = rnd ? $urandom : (32'h100 + i);
            dut.rom[i] = romm[i];
        end
    endtask

    task automatic step(input bit rdy, input bit redir, input logic [31:0] tgt);
        @(negedge clk);
        ready = rdy; redirect = redir; redirect_pc = tgt;
        model_edge(rdy, redir, tgt);
        @(posedge clk);
        #1;
    endtask

    // Hold reset, release on a falling edge, then let the IDLE edge pass.
    task automatic do_reset();
        @(negedge clk);
        rst = 1; ready = 0; redirect = 0; redirect_pc = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_edge(0, 0, '0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1;
        #1;
        checks++; if (obs !== 98'h0) begin errors++; $display("FAIL reset_values: got %h want %h", obs, 98'h0); end
        do_reset();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL idle_edge_valid: got %b want 0", valid); end
    endtask

    task automatic test_sequential();
        do_reset();
        step(1, 0, '0);
        exp_v = {1'b1, 32'h0, 32'h100, 32'd0, 1'b0};
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL seq_first: got %h want %h", obs, exp_v); end
        for (int k = 1; k <= 3; k++) begin
            step(1, 0, '0);
            exp_v = {1'b1, 32'(4 * k), 32'(32'h100 + k), 32'(k), 1'b0};
            checks++; if (obs !== exp_v) begin errors++; $display("FAIL seq_%0d: got %h want %h", k, obs, exp_v); end
        end
        step(1, 0, '0);
        checks++; if (count !== 32'd4) begin errors++; $display("FAIL seq_count4: got %0d want 4", count); end
    endtask

    task automatic test_backpressure();
        do_reset();
        repeat (3) step(1, 0, '0);
        exp_v = {1'b1, 32'h8, 32'h102, 32'd2, 1'b0};
        for (int k = 0; k < 3; k++) begin
            step(0, 0, '0);
            checks++; if (obs !== exp_v) begin errors++; $display("FAIL stall_%0d: got %h want %h", k, obs, exp_v); end
        end
        step(1, 0, '0);
        exp_v = {1'b1, 32'hC, 32'h103, 32'd3, 1'b0};
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL stall_resume: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_redirect();
        do_reset();
        step(1, 0, '0);
        step(1, 0, '0);
        step(1, 1, 32'h20);
        checks++; if (valid !== 1'b0 || pc !== 32'h4 || count !== 32'd2) begin
            errors++; $display("FAIL redirect_bubble: got v=%b pc=%h cnt=%0d want v=0 pc=4 cnt=2", valid, pc, count); end
        step(1, 0, '0);
        exp_v = {1'b1, 32'h20, 32'h108, 32'd2, 1'b0};
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL redirect_target: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (5) step(1, 0, '0);
        checks++; if (pc !== 32'h10) begin errors++; $display("FAIL async_setup_pc: got %h want 10", pc); end
        #2;
        rst = 1;
        #1;
        checks++; if (obs !== 98'h0) begin errors++; $display("FAIL async_reset: got %h want %h", obs, 98'h0); end
        model_reset();
    endtask

    task automatic test_bounds();
        do_reset();
        step(1, 0, '0);
        step(1, 1, 32'h100);
        step(1, 0, '0);
        if (BOUNDS) begin
            exp_v = {1'b0, 32'h100, 32'h100, 32'd1, 1'b1};
            checks++; if (obs !== exp_v) begin errors++; $display("FAIL bounds_fault: got %h want %h", obs, exp_v); end
            step(1, 1, 32'h20);
            step(1, 0, '0);
            checks++; if (obs !== exp_v) begin errors++; $display("FAIL bounds_sticky: got %h want %h", obs, exp_v); end
        end else begin
            exp_v = {1'b1, 32'h100, 32'h100, 32'd1, 1'b0};
            checks++; if (obs !== exp_v) begin errors++; $display("FAIL bounds_wrap: got %h want %h", obs, exp_v); end
        end
        do_reset();
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL bounds_reset: got %b want 0", fault); end
        step(1, 0, '0);
        step(1, 1, 32'h6);
        step(1, 0, '0);
        if (BOUNDS) exp_v = {1'b0, 32'h6, 32'h100, 32'd1, 1'b1};
        else        exp_v = {1'b1, 32'h6, 32'h101, 32'd1, 1'b0};
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL bounds_misalign: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        step(1, 0, '0);
        force dut.fetch_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.fetch_count_q;
        m_cnt = 32'hFFFF_FFFE;
        repeat (3) step(1, 0, '0);
        exp_v = {1'b1, 32'hC, 32'h103, 32'h1, 1'b0};
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL count_wrap: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_random();
        load_rom(1);
        do_reset();
        for (int n = 0; n < 400; n++) begin
            bit rdy;
            bit redir;
            logic [31:0] tgt;
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 7) == 0);
            tgt   = 32'($urandom_range(0, DEPTH - 1)) << 2;
            step(rdy, redir, tgt);
            exp_v = {m_valid, m_pco, m_instr, m_cnt, m_faulted};
            checks++; if (obs !== exp_v) begin errors++; $display("FAIL random_%0d: got %h want %h", n, obs, exp_v); end
        end
    endtask

    initial begin
        model_reset();
        load_rom(0);
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_async_reset();
        test_bounds();
        test_counter_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
